// File: rtl/fc_ctrl.sv
// Fully-connected layer engine: one signed MAC per cycle over NUM_IN inputs per neuron, quantised write-back.
// Build option: define FC_RELU_EN to clamp negative quantised results to zero.
module fc_ctrl #(
  parameter int DATA_W  = 8,
  parameter int ACC_W   = 24,
  parameter int NUM_IN  = 800,
  parameter int NUM_OUT = 500,
  parameter int SHIFT   = 7,
  parameter int ACT_AW  = 10,
  parameter int W_AW    = 19,
  parameter int OUT_AW  = 9
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              fc_start,
  input  logic              mem_sel,
  output logic              act_bank,
  output logic [ACT_AW-1:0] act_addr,
  input  logic [DATA_W-1:0] act_rdata,
  output logic [W_AW-1:0]   w_addr,
  input  logic [DATA_W-1:0] w_rdata,
  output logic [OUT_AW-1:0] b_addr,
  input  logic [DATA_W-1:0] b_rdata,
  output logic              out_wen,
  output logic [OUT_AW-1:0] out_addr,
  output logic [DATA_W-1:0] out_wdata,
  output logic              busy,
  output logic              fc_done
);

  typedef enum logic [2:0] {S_IDLE, S_MAC, S_DRAIN, S_WRITE, S_DONE} state_t;

  localparam logic [ACT_AW-1:0]       IN_LAST  = ACT_AW'(NUM_IN - 1);
  localparam logic [OUT_AW-1:0]       OUT_LAST = OUT_AW'(NUM_OUT - 1);
  localparam logic signed [ACC_W-1:0] SAT_HI   = ACC_W'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_LO   = ~SAT_HI;

  state_t                   state_q;
  logic [ACT_AW-1:0]        in_idx_q;
  logic [OUT_AW-1:0]        out_idx_q;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     rd_vld_q, rd_first_q;
  logic                     act_bank_q, out_wen_q, busy_q, fc_done_q;
  logic [ACT_AW-1:0]        act_addr_q;
  logic [W_AW-1:0]          w_addr_q;
  logic [OUT_AW-1:0]        b_addr_q, out_addr_q;
  logic [DATA_W-1:0]        out_wdata_q;

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext, bias_ext;

  assign prod     = $signed(act_rdata) * $signed(w_rdata);
  assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
  assign bias_ext = {{(ACC_W-DATA_W){b_rdata[DATA_W-1]}}, b_rdata};

  // The first product of a neuron seeds the accumulator with its bias instead of the old sum.
  always_comb begin
    acc_d = acc_q;
    if (rd_vld_q) begin
      acc_d = (rd_first_q ? bias_ext : acc_q) + prod_ext;
    end
  end

  function automatic logic [DATA_W-1:0] quantise(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] t;
    logic [DATA_W-1:0]       q;
    t = a >>> SHIFT;
    if (t > SAT_HI) begin
      q = {1'b0, {(DATA_W-1){1'b1}}};
    end else if (t < SAT_LO) begin
      q = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      q = t[DATA_W-1:0];
    end
`ifdef FC_RELU_EN
    if (q[DATA_W-1]) begin
      q = '0;
    end
`endif
    return q;
  endfunction

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q     <= S_IDLE;
      in_idx_q    <= '0;
      out_idx_q   <= '0;
      acc_q       <= '0;
      rd_vld_q    <= 1'b0;
      rd_first_q  <= 1'b0;
      act_bank_q  <= 1'b0;
      act_addr_q  <= '0;
      w_addr_q    <= '0;
      b_addr_q    <= '0;
      out_wen_q   <= 1'b0;
      out_addr_q  <= '0;
      out_wdata_q <= '0;
      busy_q      <= 1'b0;
      fc_done_q   <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      rd_vld_q   <= 1'b0;
      rd_first_q <= 1'b0;
      out_wen_q  <= 1'b0;
      fc_done_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (fc_start) begin
            state_q    <= S_MAC;
            busy_q     <= 1'b1;
            act_bank_q <= mem_sel;
            in_idx_q   <= '0;
            out_idx_q  <= '0;
            act_addr_q <= '0;
            w_addr_q   <= '0;
            b_addr_q   <= '0;
          end
        end
        S_MAC: begin
          rd_vld_q   <= 1'b1;
          rd_first_q <= (in_idx_q == '0);
          if (in_idx_q == IN_LAST) begin
            state_q <= S_DRAIN;
          end else begin
            in_idx_q   <= in_idx_q + ACT_AW'(1);
            act_addr_q <= in_idx_q + ACT_AW'(1);
            w_addr_q   <= w_addr_q + W_AW'(1);
          end
        end
        S_DRAIN: begin
          state_q     <= S_WRITE;
          out_wen_q   <= 1'b1;
          out_addr_q  <= out_idx_q;
          out_wdata_q <= quantise(acc_d);
        end
        S_WRITE: begin
          if (out_idx_q == OUT_LAST) begin
            state_q   <= S_DONE;
            fc_done_q <= 1'b1;
          end else begin
            // Weights are neuron-major, so the next neuron starts right after the last weight read.
            state_q    <= S_MAC;
            out_idx_q  <= out_idx_q + OUT_AW'(1);
            in_idx_q   <= '0;
            act_addr_q <= '0;
            w_addr_q   <= w_addr_q + W_AW'(1);
            b_addr_q   <= out_idx_q + OUT_AW'(1);
          end
        end
        S_DONE: begin
          state_q   <= S_IDLE;
          busy_q    <= 1'b0;
          in_idx_q  <= '0;
          out_idx_q <= '0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign act_bank  = act_bank_q;
  assign act_addr  = act_addr_q;
  assign w_addr    = w_addr_q;
  assign b_addr    = b_addr_q;
  assign out_wen   = out_wen_q;
  assign out_addr  = out_addr_q;
  assign out_wdata = out_wdata_q;
  assign busy      = busy_q;
  assign fc_done   = fc_done_q;

endmodule

// File: tb/tb_fc_ctrl.sv
// Bench for fc_ctrl: a small 4x2 instance for directed/control scenarios and a 40x25 instance with random data.
module tb_fc_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic [8:0] a;
    logic [7:0] d;
  } wr_t;

  // Reference quantiser: wrap to 24 bits, arithmetic shift, saturate to int8, optional ReLU.
  function automatic logic [7:0] q_ref(input longint acc, input int shift);
    logic signed [23:0] a24;
    longint t;
    a24 = acc[23:0];
    t = a24;
    t = t >>> shift;
    if (t > 127) t = 127;
    if (t < -128) t = -128;
`ifdef FC_RELU_EN
    if (t < 0) t = 0;
`endif
    return 8'(t);
  endfunction

  // ---------------- small instance: NUM_IN=4, NUM_OUT=2, SHIFT=0 ----------------
  logic       s_srst, s_start, s_sel;
  logic       s_act_bank, s_out_wen, s_busy, s_fc_done;
  logic [9:0] s_act_addr;
  logic [18:0] s_w_addr;
  logic [8:0] s_b_addr, s_out_addr;
  logic [7:0] s_act_rdata, s_w_rdata, s_b_rdata, s_out_wdata;
  logic [7:0] s_act0 [64];
  logic [7:0] s_act1 [64];
  logic [7:0] s_w    [64];
  logic [7:0] s_b    [16];
  wr_t        s_wq   [$];

  fc_ctrl #(.DATA_W(8), .ACC_W(24), .NUM_IN(4), .NUM_OUT(2), .SHIFT(0),
            .ACT_AW(10), .W_AW(19), .OUT_AW(9)) u_small (
    .clk(clk), .srst(s_srst), .fc_start(s_start), .mem_sel(s_sel),
    .act_bank(s_act_bank), .act_addr(s_act_addr), .act_rdata(s_act_rdata),
    .w_addr(s_w_addr), .w_rdata(s_w_rdata), .b_addr(s_b_addr), .b_rdata(s_b_rdata),
    .out_wen(s_out_wen), .out_addr(s_out_addr), .out_wdata(s_out_wdata),
    .busy(s_busy), .fc_done(s_fc_done)
  );

  always @(posedge clk) begin
    s_act_rdata <= s_act_bank ? s_act1[s_act_addr[5:0]] : s_act0[s_act_addr[5:0]];
    s_w_rdata   <= s_w[s_w_addr[5:0]];
    s_b_rdata   <= s_b[s_b_addr[3:0]];
  end

  always @(negedge clk) if (s_out_wen === 1'b1) s_wq.push_back('{s_out_addr, s_out_wdata});

  function automatic logic [7:0] s_expect(input int o, input bit sel);
    longint acc;
    int av, wv;
    acc = $signed(s_b[o]);
    for (int i = 0; i < 4; i++) begin
      av = sel ? $signed(s_act1[i]) : $signed(s_act0[i]);
      wv = $signed(s_w[o*4 + i]);
      acc += av * wv;
    end
    return q_ref(acc, 0);
  endfunction

  function automatic logic [7:0] s_wq_data(input int k);
    if (k < s_wq.size()) return s_wq[k].d;
    return 8'bx;
  endfunction

  task automatic s_check_writes(input bit sel, input int n_exp, input string tag);
    chk({tag, "_nwrites"}, s_wq.size(), n_exp);
    for (int k = 0; k < s_wq.size() && k < n_exp; k++) begin
      $display("%s write %0d: addr=%0d data=%02h", tag, k, s_wq[k].a, s_wq[k].d);
      chk({tag, "_addr"}, 32'(s_wq[k].a), k % 2);
      chk({tag, "_data"}, 32'(s_wq[k].d), 32'(s_expect(k % 2, sel)));
    end
  endtask

  // mode 0: plain run; 1: start pulse and mem_sel toggle mid-run; 2: fc_start held high through DONE.
  task automatic s_run(input bit sel, input int mode, output int done_cyc);
    int cyc;
    bit seen;
    s_wq.delete();
    s_sel = sel;
    @(negedge clk) s_start = 1'b1;
    @(negedge clk);
    if (mode != 2) s_start = 1'b0;
    cyc = 1;
    done_cyc = -1;
    while (cyc <= 40 && done_cyc < 0) begin
      if (mode == 1 && cyc == 3) s_start = 1'b1;
      if (mode == 1 && cyc == 4) s_start = 1'b0;
      if (mode == 1 && cyc == 5) s_sel = ~sel;
      chk("act_bank", s_act_bank, sel);
      chk("addr_rel", s_w_addr, 32'(s_b_addr) * 4 + 32'(s_act_addr));
      if (s_fc_done === 1'b1) done_cyc = cyc;
      @(negedge clk);
      cyc++;
    end
    chk("busy_after_done", s_busy, 1'b0);
    chk("done_one_cycle", s_fc_done, 1'b0);
    if (mode == 2) begin
      @(negedge clk);
      chk("restart_busy", s_busy, 1'b1);
      s_start = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
        if (s_fc_done === 1'b1) seen = 1'b1;
        @(negedge clk);
      end
      chk("restart_done", seen, 1'b1);
    end
  endtask

  // ---------------- larger instance: NUM_IN=40, NUM_OUT=25, SHIFT=7 ----------------
  logic       b_srst, b_start, b_sel;
  logic       b_act_bank, b_out_wen, b_busy, b_fc_done;
  logic [9:0] b_act_addr;
  logic [18:0] b_w_addr;
  logic [8:0] b_b_addr, b_out_addr;
  logic [7:0] b_act_rdata, b_w_rdata, b_b_rdata, b_out_wdata;
  logic [7:0] b_act0 [64];
  logic [7:0] b_act1 [64];
  logic [7:0] b_w    [1024];
  logic [7:0] b_b    [32];
  wr_t        b_wq   [$];

  fc_ctrl #(.DATA_W(8), .ACC_W(24), .NUM_IN(40), .NUM_OUT(25), .SHIFT(7),
            .ACT_AW(10), .W_AW(19), .OUT_AW(9)) u_big (
    .clk(clk), .srst(b_srst), .fc_start(b_start), .mem_sel(b_sel),
    .act_bank(b_act_bank), .act_addr(b_act_addr), .act_rdata(b_act_rdata),
    .w_addr(b_w_addr), .w_rdata(b_w_rdata), .b_addr(b_b_addr), .b_rdata(b_b_rdata),
    .out_wen(b_out_wen), .out_addr(b_out_addr), .out_wdata(b_out_wdata),
    .busy(b_busy), .fc_done(b_fc_done)
  );

  always @(posedge clk) begin
    b_act_rdata <= b_act_bank ? b_act1[b_act_addr[5:0]] : b_act0[b_act_addr[5:0]];
    b_w_rdata   <= b_w[b_w_addr[9:0]];
    b_b_rdata   <= b_b[b_b_addr[4:0]];
  end

  always @(negedge clk) if (b_out_wen === 1'b1) b_wq.push_back('{b_out_addr, b_out_wdata});

  function automatic logic [7:0] b_expect(input int o, input bit sel);
    longint acc;
    int av, wv;
    acc = $signed(b_b[o]);
    for (int i = 0; i < 40; i++) begin
      av = sel ? $signed(b_act1[i]) : $signed(b_act0[i]);
      wv = $signed(b_w[o*40 + i]);
      acc += av * wv;
    end
    return q_ref(acc, 7);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc, cyc, wmax;
    bit saw, rsel;
    logic [7:0] neg_exp;
    s_srst = 1'b1; s_start = 1'b0; s_sel = 1'b0;
    b_srst = 1'b1; b_start = 1'b0; b_sel = 1'b0;
    for (int i = 0; i < 64; i++) begin s_act0[i] = '0; s_act1[i] = '0; s_w[i] = '0; end
    for (int i = 0; i < 16; i++) s_b[i] = '0;
    repeat (3) @(negedge clk);

    chk("rst_busy", s_busy, 1'b0);
    chk("rst_done", s_fc_done, 1'b0);
    chk("rst_wen", s_out_wen, 1'b0);
    chk("rst_bank", s_act_bank, 1'b0);
    chk("rst_act_addr", s_act_addr, 0);
    chk("rst_w_addr", s_w_addr, 0);
    chk("rst_b_addr", s_b_addr, 0);
    chk("rst_wdata", s_out_wdata, 0);
    chk("rst_big_busy", b_busy, 1'b0);
    s_srst = 1'b0; b_srst = 1'b0;
    @(negedge clk);

    // Ones: only bank 1 holds ones, so a wrong bank reads zeros.
    for (int i = 0; i < 64; i++) begin s_act1[i] = 8'd1; s_act0[i] = 8'd0; s_w[i] = 8'd1; end
    for (int i = 0; i < 16; i++) s_b[i] = 8'd0;
    s_run(1'b1, 0, dc);
    chk("ones_done_cycle", dc, 13);
    s_check_writes(1'b1, 2, "ones");
    chk("ones_n0", s_wq_data(0), 8'd4);
    chk("ones_n1", s_wq_data(1), 8'd4);

    // Signed: neuron 0 sums to -4.
    s_act0[0] = 8'(3); s_act0[1] = 8'(-2); s_act0[2] = 8'(5); s_act0[3] = 8'(-1);
    s_w[0] = 8'(2); s_w[1] = 8'(4); s_w[2] = 8'(-1); s_w[3] = 8'(7);
    for (int i = 4; i < 8; i++) s_w[i] = 8'($urandom);
    s_b[0] = 8'(10); s_b[1] = 8'($urandom);
`ifdef FC_RELU_EN
    neg_exp = 8'h00;
`else
    neg_exp = 8'hFC;
`endif
    s_run(1'b0, 0, dc);
    chk("signed_done_cycle", dc, 13);
    s_check_writes(1'b0, 2, "signed");
    chk("signed_n0", s_wq_data(0), neg_exp);

    // Saturation at both ends.
    for (int i = 0; i < 64; i++) begin s_act0[i] = 8'd127; s_w[i] = 8'd127; end
    for (int i = 0; i < 16; i++) s_b[i] = 8'd127;
    s_run(1'b0, 0, dc);
    chk("sat_pos_n0", s_wq_data(0), 8'd127);
    chk("sat_pos_n1", s_wq_data(1), 8'd127);
    for (int i = 0; i < 64; i++) s_w[i] = 8'h80;
`ifdef FC_RELU_EN
    neg_exp = 8'h00;
`else
    neg_exp = 8'h80;
`endif
    s_run(1'b0, 0, dc);
    chk("sat_neg_n0", s_wq_data(0), neg_exp);
    chk("sat_neg_n1", s_wq_data(1), neg_exp);

    // Control robustness: start pulse and mem_sel toggle while busy.
    for (int i = 0; i < 64; i++) begin
      s_act0[i] = 8'($urandom); s_act1[i] = 8'($urandom); s_w[i] = 8'($urandom);
    end
    for (int i = 0; i < 16; i++) s_b[i] = 8'($urandom);
    s_run(1'b1, 1, dc);
    chk("disturb_done_cycle", dc, 13);
    s_check_writes(1'b1, 2, "disturb");

    // Reset during the second neuron's MAC phase aborts the run.
    s_wq.delete();
    s_sel = 1'b1;
    @(negedge clk) s_start = 1'b1;
    @(negedge clk) s_start = 1'b0;
    repeat (7) @(negedge clk);
    chk("abort_pre_busy", s_busy, 1'b1);
    s_srst = 1'b1;
    @(negedge clk);
    chk("abort_busy", s_busy, 1'b0);
    chk("abort_wen", s_out_wen, 1'b0);
    chk("abort_done", s_fc_done, 1'b0);
    chk("abort_bank", s_act_bank, 1'b0);
    s_srst = 1'b0;
    saw = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (s_fc_done !== 1'b0 || s_out_wen !== 1'b0) saw = 1'b1;
    end
    chk("abort_quiet", saw, 1'b0);
    chk("abort_nwrites", s_wq.size(), 1);
    s_run(1'b0, 0, dc);
    chk("after_abort_done_cycle", dc, 13);
    s_check_writes(1'b0, 2, "after_abort");

    // fc_start held high: ignored in DONE, restarts from IDLE.
    s_run(1'b0, 2, dc);
    chk("hold_done_cycle", dc, 13);
    s_check_writes(1'b0, 4, "hold");

    // Random small runs.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 64; i++) begin
        s_act0[i] = 8'($urandom); s_act1[i] = 8'($urandom); s_w[i] = 8'($urandom);
      end
      for (int i = 0; i < 16; i++) s_b[i] = 8'($urandom);
      rsel = 1'($urandom_range(0, 1));
      s_run(rsel, 0, dc);
      chk("rand_done_cycle", dc, 13);
      s_check_writes(rsel, 2, "rand");
    end

    // Larger configuration with random data; narrower weights keep many results in range.
    for (int i = 0; i < 64; i++) begin b_act0[i] = 8'($urandom); b_act1[i] = 8'($urandom); end
    for (int i = 0; i < 1024; i++) b_w[i] = 8'($urandom_range(0, 31)) - 8'd16;
    for (int i = 0; i < 32; i++) b_b[i] = 8'($urandom);
    b_sel = 1'($urandom_range(0, 1));
    b_wq.delete();
    @(negedge clk) b_start = 1'b1;
    @(negedge clk) b_start = 1'b0;
    cyc = 1; dc = -1; wmax = 0;
    while (cyc <= 1200 && dc < 0) begin
      if (int'(b_w_addr) > wmax) wmax = int'(b_w_addr);
      if (cyc == 100) chk("big_bank", b_act_bank, b_sel);
      if (b_fc_done === 1'b1) dc = cyc;
      @(negedge clk);
      cyc++;
    end
    chk("big_done_cycle", dc, 25 * 42 + 1);
    chk("big_w_addr_max", wmax, 999);
    chk("big_busy_after", b_busy, 1'b0);
    chk("big_nwrites", b_wq.size(), 25);
    for (int k = 0; k < b_wq.size() && k < 25; k++) begin
      $display("big write %0d: addr=%0d data=%02h", k, b_wq[k].a, b_wq[k].d);
      chk("big_addr", 32'(b_wq[k].a), k);
      chk("big_data", 32'(b_wq[k].d), 32'(b_expect(k, b_sel)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fc_ctrl.md
Name: fc_ctrl

Overview:
- Fully-connected layer engine downstream of the conv controller.
- fc_start is pulsed by the top level once the conv controller signals conv_done. The block then reads the flattened conv output from the ping-pong bank named by mem_sel, together with weights and biases.
- It runs one scalar signed MAC per cycle, writes one quantised result per output neuron, and pulses fc_done. fc_done is what flips mem_sel back in the conv controller.

Parameters:
- DATA_W, 8: activation, weight, bias and output width (signed two's complement).
- ACC_W, 24: accumulator width (signed).
- NUM_IN, 800: inputs per neuron.
- NUM_OUT, 500: number of output neurons.
- SHIFT, 7: arithmetic right shift applied to the accumulator before saturation.
- ACT_AW, 10: activation address width.
- W_AW, 19: weight address width; must satisfy 2^W_AW >= NUM_IN*NUM_OUT.
- OUT_AW, 9: output and bias address width.

Ports:
- clk, in, 1: clock, rising edge.
- srst, in, 1: synchronous reset, active-high.
- fc_start, in, 1: start pulse; sampled only in IDLE.
- mem_sel, in, 1: conv bank select (0: c0~c4, 1: d0~d4); latched at start.
- act_bank, out, 1: bank being read; equals mem_sel latched at start.
- act_addr, out, ACT_AW: activation read address.
- act_rdata, in, DATA_W: activation data; valid 1 cycle after act_addr.
- w_addr, out, W_AW: weight read address.
- w_rdata, in, DATA_W: weight data; valid 1 cycle after w_addr.
- b_addr, out, OUT_AW: bias read address.
- b_rdata, in, DATA_W: bias data; valid 1 cycle after b_addr.
- out_wen, out, 1: output write strobe.
- out_addr, out, OUT_AW: output write address (neuron index).
- out_wdata, out, DATA_W: quantised neuron result.
- busy, out, 1: high in every state except IDLE.
- fc_done, out, 1: one-cycle completion pulse.

Behaviour:
- Reset (srst=1 at an edge):
  - State goes to IDLE; in_idx=0, out_idx=0, acc=0.
  - All outputs are 0 (act_bank=0).
  - Reset mid-operation aborts immediately, with no further write and no fc_done.
- States:
  - IDLE -> MAC when fc_start=1; mem_sel is latched into act_bank on the same edge.
  - MAC: lasts NUM_IN cycles, with in_idx running 0..NUM_IN-1.
    - act_addr=in_idx.
    - w_addr=out_idx*NUM_IN+in_idx (registered or incremental; no multiplier on the critical path is required).
    - b_addr=out_idx.
    - At in_idx=NUM_IN-1 go to DRAIN.
  - DRAIN: 1 cycle; consumes the last returned product. Next state is WRITE.
  - WRITE: 1 cycle.
    - out_wen=1, out_addr=out_idx, out_wdata=Q(acc).
    - If out_idx=NUM_OUT-1 go to DONE. Otherwise out_idx++, in_idx=0, and go to MAC.
  - DONE: fc_done=1 for 1 cycle, then IDLE. out_idx and in_idx return to 0.
- Data pipeline:
  - A 1-cycle valid flag tracks each MAC read.
  - On the cycle data for in_idx=0 returns: acc = sext(b_rdata) + sext(act_rdata*w_rdata).
  - Afterwards: acc += sext(act_rdata*w_rdata).
  - The product is signed 2*DATA_W, sign-extended to ACC_W.
  - Accumulator overflow wraps; sizing ACC_W adequately is the integrator's job.
- Quantiser Q:
  - t = acc >>> SHIFT (arithmetic).
  - Saturate t to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - Optional ReLU, see below.
- Timing:
  - Each neuron takes NUM_IN+2 cycles.
  - fc_done is asserted NUM_OUT*(NUM_IN+2)+1 cycles after the edge that sampled fc_start.
- Boundary rules:
  - fc_start while busy is ignored.
  - mem_sel changing mid-run has no effect (the latched value is used).
  - fc_start high in DONE is ignored; a new run needs fc_start in IDLE.
  - fc_start held high continuously restarts one cycle after fc_done.
  - Read addresses hold their last value outside MAC; out_wen=0 outside WRITE.

Optional Feature:
- Macro: FC_RELU_EN.
- Defined: after saturation, negative results are forced to 0, so out_wdata is in [0, 2^(DATA_W-1)-1].
- Undefined: full signed saturation, with no ReLU.

Test Plan:
- Test configuration for all scenarios except the last: NUM_IN=4, NUM_OUT=2, SHIFT=0.
- Ones test: all activations=1, weights=1, biases=0, mem_sel=1 at start -> act_bank=1, two writes (addr 0 then 1) with data 4, fc_done on cycle 2*6+1=13 after start, busy low the cycle after.
- Signed test: acts {3,-2,5,-1}, weights of neuron 0 {2,4,-1,7}, bias 10 -> acc = 6-8-5-7+10 = -4. Expected out_wdata=-4 (0xFC) without FC_RELU_EN and 0 with it.
- Saturation test: acts=127, weights=127, bias=127 -> out_wdata=127. With acts=127, weights=-128 and FC_RELU_EN undefined -> out_wdata=-128.
- Control robustness:
  - Pulse fc_start mid-run, and toggle mem_sel mid-run -> no restart, act_bank unchanged, exactly NUM_OUT writes.
  - Assert srst during the second MAC -> next cycle: busy=0, out_wen=0, no fc_done. A subsequent fc_start completes normally.
- Full-size run (defaults, random data) vs reference model -> 500 writes matching, w_addr reaching 399999, fc_done at cycle 500*802+1.
